// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional early J-type resolution at fetch when FETCH_JUMP_EN is defined.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IfInstruction,
  output logic [31:0] IfPcPlus4,
  output logic        IfValid,
  output logic [31:0] FetchCount
);

  localparam int unsigned XLEN = 32;
  localparam logic [5:0] OP_J = 6'b000010;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] seq_next_pc;
  logic [XLEN-1:0] redirect_pc;
  logic            branch_lo_unused;

  assign Address          = pc;
  assign pc_plus4         = pc + XLEN'(4);
  assign redirect_pc      = {BranchTarget[31:2], 2'b00};
  assign branch_lo_unused = ^BranchTarget[1:0];

  // PC that follows an advance: sequential, or a J target resolved at fetch
`ifdef FETCH_JUMP_EN
  logic is_jump;
  assign is_jump = (Instruction[31:26] == OP_J);

  always_comb begin
    seq_next_pc = pc_plus4;
    if (is_jump) begin
      seq_next_pc = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    end
  end
`else
  logic [5:0] op_unused;
  assign op_unused = OP_J;

  always_comb begin
    seq_next_pc = pc_plus4;
  end
`endif

  // Priority: redirect over hold over advance
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc            <= RESET_PC;
      IfInstruction <= '0;
      IfPcPlus4     <= '0;
      IfValid       <= 1'b0;
      FetchCount    <= '0;
    end else if (BranchTaken) begin
      pc      <= redirect_pc;
      IfValid <= 1'b0;
    end else if (!Stall) begin
      pc            <= seq_next_pc;
      IfInstruction <= Instruction;
      IfPcPlus4     <= pc_plus4;
      IfValid       <= 1'b1;
      FetchCount    <= FetchCount + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// stall/redirect/reset traffic checked every cycle against a behavioural model.
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic [31:0] IfInstruction;
  logic [31:0] IfPcPlus4;
  logic        IfValid;
  logic [31:0] FetchCount;

  logic        rst1 = 1'b0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic [31:0] address1, instr1, ifins1, ifpc4_1, fcnt1;
  logic        ifvalid1;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  // Instruction memory: fixed words at 0 and 0x60, J words on a sparse set of lines
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (a == 32'h0) return 32'h2402_0008;
    if (a == 32'h60) return 32'h0810_0005;
    if (a == 32'hFFFF_FFFC) return {6'b001001, h[25:0]};
    if (a[7:2] == 6'h3f) return {6'b000010, h[25:0]};
    if (h[31:26] == 6'b000010) h[31] = 1'b1;
    return h;
  endfunction

  assign Instruction = mem(Address);
  assign instr1      = mem(address1);

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .Clock(Clock), .Reset(Reset), .Address(Address), .Instruction(Instruction),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IfInstruction(IfInstruction), .IfPcPlus4(IfPcPlus4), .IfValid(IfValid),
    .FetchCount(FetchCount)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clock(Clock), .Reset(rst1), .Address(address1), .Instruction(instr1),
    .Stall(zero1), .BranchTaken(zero1), .BranchTarget(zero32),
    .IfInstruction(ifins1), .IfPcPlus4(ifpc4_1), .IfValid(ifvalid1),
    .FetchCount(fcnt1)
  );

  // Behavioural model of the RESET_PC=0 instance
  logic [31:0] m_pc = '0, m_ins = '0, m_pc4 = '0, m_cnt = '0;
  logic        m_valid = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    logic [31:0] w, nxt;
    if (Reset) begin
      m_pc = '0; m_ins = '0; m_pc4 = '0; m_valid = 1'b0; m_cnt = '0;
    end else if (BranchTaken) begin
      m_pc = BranchTarget & 32'hFFFF_FFFC;
      m_valid = 1'b0;
    end else if (!Stall) begin
      w   = mem(m_pc);
      nxt = m_pc + 32'd4;
`ifdef FETCH_JUMP_EN
      if (w[31:26] == 6'b000010) nxt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'b0, w[25:0], 2'b00};
`endif
      m_ins = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      m_pc = nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge Clock) begin
    chk("model_address", Address, m_pc);
    chk("model_ifinstr", IfInstruction, m_ins);
    chk("model_ifpc4", IfPcPlus4, m_pc4);
    chk("model_ifvalid", {31'b0, IfValid}, {31'b0, m_valid});
    chk("model_count", FetchCount, m_cnt);
  end

  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt);
    @(negedge Clock); #1;
    Stall = st; BranchTaken = br; BranchTarget = tgt;
    @(posedge Clock); #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1; #1; Reset = 1'b0;
  endtask

  logic [31:0] exp_jump;

  initial begin
    rst1 = 1'b1;
    #1 Reset = 1'b1;
    #1;
    chk("reset_address", Address, 32'h0);
    chk("reset_valid", {31'b0, IfValid}, 32'h0);
    chk("reset_count", FetchCount, 32'h0);
    chk("wrap_reset_address", address1, 32'hFFFF_FFFC);

    // Free run from 0
    @(negedge Clock); #1; Reset = 1'b0;
    chk("run_addr0", Address, 32'h0);
    @(posedge Clock); #1;
    chk("run_addr4", Address, 32'h4);
    chk("run_ifinstr", IfInstruction, 32'h2402_0008);
    chk("run_ifpc4", IfPcPlus4, 32'h4);
    cyc(1'b0, 1'b0, 32'h0);
    chk("run_addr8", Address, 32'h8);
    cyc(1'b0, 1'b0, 32'h0);
    chk("run_addr12", Address, 32'hC);
    chk("run_count3", FetchCount, 32'd3);

    // Stall at 8 then redirect with stall still high
    pulse_reset();
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("stall_pre_addr", Address, 32'h8);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("stall_addr", Address, 32'h8);
    chk("stall_ifpc4", IfPcPlus4, 32'h8);
    chk("stall_count", FetchCount, 32'd2);
    chk("stall_valid", {31'b0, IfValid}, 32'h1);
    cyc(1'b1, 1'b1, 32'h0000_0017);
    chk("redir_addr", Address, 32'h14);
    chk("redir_valid", {31'b0, IfValid}, 32'h0);
    chk("redir_count", FetchCount, 32'd2);
    chk("redir_ifpc4", IfPcPlus4, 32'h8);

    // Jump word at 0x60
    cyc(1'b0, 1'b1, 32'h60);
    chk("jump_pc", Address, 32'h60);
    cyc(1'b0, 1'b0, 32'h0);
`ifdef FETCH_JUMP_EN
    exp_jump = 32'h0040_0014;
`else
    exp_jump = 32'h0000_0064;
`endif
    chk("jump_next_addr", Address, exp_jump);
    chk("jump_valid", {31'b0, IfValid}, 32'h1);
    chk("jump_ifinstr", IfInstruction, 32'h0810_0005);

    // PC wrap on the second instance
    @(negedge Clock); #1; rst1 = 1'b0;
    @(posedge Clock); #1;
    chk("wrap_addr", address1, 32'h0);
    chk("wrap_ifpc4", ifpc4_1, 32'h0);
    chk("wrap_valid", {31'b0, ifvalid1}, 32'h1);

    // Reset between edges after five advances
    pulse_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("mid_pre_count", FetchCount, 32'd5);
    Reset = 1'b1; #1;
    chk("mid_addr", Address, 32'h0);
    chk("mid_valid", {31'b0, IfValid}, 32'h0);
    chk("mid_count", FetchCount, 32'h0);
    chk("mid_ifinstr", IfInstruction, 32'h0);
    Reset = 1'b0;
    @(posedge Clock); #1;
    chk("mid_after_addr", Address, 32'h4);
    chk("mid_after_count", FetchCount, 32'd1);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = {24'h0, 2'b01, t[5:0]};
      @(negedge Clock); #1;
      Stall        = ($urandom_range(0, 3) == 0);
      BranchTaken  = ($urandom_range(0, 9) == 0);
      BranchTarget = t;
      Reset        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end
    @(negedge Clock); #1;
    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port Clock  input  1  single clock for all state; rising-edge triggered.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Address  output  32  fetch address to instruction memory; equals current PC.
REQ-005 SHALL have port Instruction  input  32  word returned combinationally by instruction memory for Address in the same cycle.
REQ-006 SHALL have port Stall  input  1  downstream hold request.
REQ-007 SHALL have port BranchTaken  input  1  downstream redirect request, one-cycle pulse.
REQ-008 SHALL have port BranchTarget  input  32  redirect address; bits [1:0] ignored.
REQ-009 SHALL have port IfInstruction  output  32  registered fetched instruction (IF/ID).
REQ-010 SHALL have port IfPcPlus4  output  32  registered PC+4 of IfInstruction.
REQ-011 SHALL have port IfValid  output  1  IfInstruction/IfPcPlus4 hold a live instruction.
REQ-012 SHALL have port FetchCount  output  32  count of instructions accepted into IF/ID.

Function
REQ-013 SHALL drive Address from the PC register; Address[1:0] always 2'b00.
REQ-014 SHALL, per rising edge, select exactly one action with priority BranchTaken > Stall > advance.
REQ-015 SHALL on BranchTaken=1: PC <= {BranchTarget[31:2],2'b00}; IfValid <= 0; IfInstruction, IfPcPlus4 unchanged; FetchCount unchanged; regardless of Stall.
REQ-016 SHALL on Stall=1, BranchTaken=0: hold PC, IfInstruction, IfPcPlus4, IfValid, FetchCount.
REQ-017 SHALL on advance: IfInstruction <= Instruction; IfPcPlus4 <= PC+4; IfValid <= 1; FetchCount <= FetchCount+1; PC <= next-PC (REQ-018/REQ-027).
REQ-018 SHALL compute sequential next-PC as PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 SHALL give one-cycle latency: word at Address in cycle N appears on IfInstruction after edge N+1; no delay slots.
REQ-020 SHALL wrap FetchCount from 32'hFFFF_FFFF to 0 without side effects.
REQ-021 SHALL treat Instruction as unconditionally valid (no memory handshake); no bus or misalignment errors are generated.

Reset
REQ-022 SHALL, while Reset=1, immediately force PC=RESET_PC, IfInstruction=0, IfPcPlus4=0, IfValid=0, FetchCount=0, independent of Clock.
REQ-023 SHALL, when Reset is asserted mid-operation (incl. during Stall or BranchTaken), discard all in-flight state and apply REQ-022.
REQ-024 SHALL, on the first edge after Reset deasserts, perform a normal advance from RESET_PC unless Stall or BranchTaken is asserted.

Configuration
REQ-025 SHALL compile early jump resolution in only when macro FETCH_JUMP_EN is defined.
REQ-026 SHALL, with FETCH_JUMP_EN, decode Instruction[31:26]==6'b000010 (J) combinationally during fetch.
REQ-027 SHALL, with FETCH_JUMP_EN and a J fetched on an advance, set PC <= {(PC+4)[31:28], Instruction[25:0], 2'b00}; the J still enters IF/ID with IfValid=1 and counts in FetchCount; BranchTaken and Stall keep priority.
REQ-028 SHALL, without FETCH_JUMP_EN, treat J as any other word (PC+4); jumps resolve downstream via BranchTaken.

Verification
REQ-029 SHALL cover reset: Reset=1 with RESET_PC=0 -> Address=0, IfValid=0, FetchCount=0 immediately, no Clock edge needed.
REQ-030 SHALL cover free-run: 3 edges, no Stall/BranchTaken, memory word 32'h24020008 at 0 -> Address 0,4,8,12; IfInstruction=32'h24020008, IfPcPlus4=4 after first edge; FetchCount=3.
REQ-031 SHALL cover stall then redirect: Stall=1 for 2 edges at Address=8 -> all outputs frozen; then Stall=1 with BranchTaken=1, BranchTarget=32'h0000_0017 -> Address=32'h14, IfValid=0, FetchCount unchanged.
REQ-032 SHALL cover jump: PC=32'h60, Instruction=32'h08100005, advance -> next Address=32'h0040_0014 with FETCH_JUMP_EN, 32'h64 without; IfValid=1 both.
REQ-033 SHALL cover wrap: RESET_PC=32'hFFFF_FFFC, one advance -> Address=0, IfPcPlus4=0.
REQ-034 SHALL cover reset mid-stream: Reset pulsed between edges after 5 advances -> outputs return to reset values immediately; next edge fetches RESET_PC.
